seq_add_n: RTL and testbench

- Parametrised, multi-cycle adder/subtractor; successor to the 16-bit combinational add16.
- Processes WIDTH-bit operands CHUNK bits per clock using a start/busy/done handshake.
- Produces the sum or difference plus carry, signed-overflow and zero flags.
- Used as the ALU arithmetic core wherever area matters more than single-cycle latency.

---
 rtl/seq_add_n.sv | 140 ++++++++++++++
 tb/tb_seq_add_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_n.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock,
// LSB chunk first, with carry, signed-overflow and zero flags reported at completion.
module seq_add_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam bit BAD_CFG    = (CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0);
    localparam int N          = WIDTH / SAFE_CHUNK;
    localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (BAD_CFG) begin : g_bad_cfg
            $error("seq_add_n: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             run_c;
    logic             sign_a;
    logic             sign_b;
    logic [CNT_W-1:0] cnt;
    logic [CHUNK:0]   csum;
    logic             last;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Operands of equal sign producing a result of the other sign cannot be represented.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Chunk adder: partial sum enters the result register from the top so that
    // after N passes the first (least significant) chunk sits at bit 0.
    always_comb begin
        csum     = add_chunk(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], run_c);
        res_next = (res_sh >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (state == RUN) && (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture on start, one chunk per RUN edge, publish results on the last chunk.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            run_c    <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            out      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sh   <= a;
                    b_sh   <= sub ? ~b : b;
                    run_c  <= sub;
                    sign_a <= a[WIDTH-1];
                    sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt    <= '0;
                end
            end else begin
                a_sh   <= a_sh >> CHUNK;
                b_sh   <= b_sh >> CHUNK;
                res_sh <= res_next;
                run_c  <= csum[CHUNK];
                cnt    <= cnt + 1'b1;
                if (last) begin
                    out      <= res_next;
                    carry    <= csum[CHUNK];
                    overflow <= signed_ovf(sign_a, sign_b, res_next[WIDTH-1]);
                    zero     <= (res_next == '0);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_add_n.sv
// Bench for seq_add_n: three configurations (16/4, 16/16, 8/2) checked against
// an arithmetic reference model, plus handshake and reset corner cases.
module tb_seq_add_n;

    logic        clk;
    logic        reset;
    logic [2:0]  start_v;
    logic        op_sub;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        busy0, done0, c0, v0, z0;
    logic [15:0] out0;
    logic        busy1, done1, c1, v1, z1;
    logic [15:0] out1;
    logic        busy2, done2, c2, v2, z2;
    logic [7:0]  out2;

    seq_add_n #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(op_sub), .a(op_a), .b(op_b),
        .busy(busy0), .done(done0), .out(out0), .carry(c0), .overflow(v0), .zero(z0)
    );

    seq_add_n #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(op_sub), .a(op_a), .b(op_b),
        .busy(busy1), .done(done1), .out(out1), .carry(c1), .overflow(v1), .zero(z1)
    );

    seq_add_n #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(op_sub), .a(op_a[7:0]), .b(op_b[7:0]),
        .busy(busy2), .done(done2), .out(out2), .carry(c2), .overflow(v2), .zero(z2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    int WID[3] = '{16, 16, 8};
    int NCH[3] = '{4, 1, 4};

    longint p_out[3];
    bit     p_c[3];
    bit     p_v[3];
    bit     p_z[3];

    logic        m_busy, m_done, m_c, m_v, m_z;
    logic [31:0] m_out;

    always_comb begin
        m_busy = busy0; m_done = done0; m_c = c0; m_v = v0; m_z = z0; m_out = 32'(out0);
        case (sel)
            1: begin m_busy = busy1; m_done = done1; m_c = c1; m_v = v1; m_z = z1; m_out = 32'(out1); end
            2: begin m_busy = busy2; m_done = done2; m_c = c2; m_v = v2; m_z = z2; m_out = 32'(out2); end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned and signed interpretations evaluated with wide integers.
    function automatic void model(input int w, input longint ua, input longint ub, input bit is_sub,
                                  output longint r, output bit c, output bit v, output bit z);
        longint m, sa, sb, s;
        m  = longint'(1) << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (is_sub) begin
            r = ua - ub;
            c = (ua >= ub);
            s = sa - sb;
        end else begin
            r = ua + ub;
            c = (r >= m);
            s = sa + sb;
        end
        r = r & (m - 1);
        v = (s >= m / 2) || (s < -(m / 2));
        z = (r == 0);
    endfunction

    task automatic reset_prev();
        for (int i = 0; i < 3; i++) begin
            p_out[i] = 0; p_c[i] = 0; p_v[i] = 0; p_z[i] = 1;
        end
    endtask

    task automatic run_op(input int s, input longint av, input longint bv, input bit is_sub);
        longint r;
        bit c, v, z;
        int cyc;
        sel        = s;
        op_a       = av[15:0];
        op_b       = bv[15:0];
        op_sub     = is_sub;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        cyc = 0;
        while (!m_done && cyc < 40) begin
            check("busy_run", m_busy, 1);
            check("out_hold", m_out, p_out[s]);
            check("flags_hold", {m_c, m_v, m_z}, {p_c[s], p_v[s], p_z[s]});
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, NCH[s]);
        model(WID[s], av, bv, is_sub, r, c, v, z);
        check("out", m_out, r);
        check("carry", m_c, c);
        check("overflow", m_v, v);
        check("zero", m_z, z);
        check("busy_at_done", m_busy, 0);
        p_out[s] = r; p_c[s] = c; p_v[s] = v; p_z[s] = z;
        @(posedge clk); #1;
        check("done_one_cycle", m_done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint r;
        bit c, v, z;
        reset   = 1'b1;
        start_v = 3'b111;
        op_sub  = 1'b0;
        op_a    = 16'h1234;
        op_b    = 16'h1111;
        reset_prev();

        // reset held two cycles with start asserted
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_busy", busy0, 0);
            check("rst_done", done0, 0);
            check("rst_out", out0, 16'h0000);
            check("rst_flags", {c0, v0, z0}, 3'b001);
        end
        reset   = 1'b0;
        start_v = 3'b000;
        @(posedge clk); #1;
        check("no_start_after_rst", {busy0, busy1, busy2, done0, done1, done2}, 6'b0);

        // directed arithmetic, 16/4
        run_op(0, 16'h0000, 16'hFFFF, 0);
        run_op(0, 16'hFFFF, 16'hFFFF, 0);
        check("ffff_ffff_out", m_out, 32'h0000FFFE);
        run_op(0, 16'h1234, 16'h9876, 0);
        check("carry_chain_out", m_out, 32'h0000AAAA);
        run_op(0, 16'h0001, 16'hFFFF, 0);
        check("wrap_zero", m_z, 1);
        run_op(0, 16'h8000, 16'h0001, 1);
        check("sub_ovf", {m_c, m_v}, 2'b11);
        run_op(0, 16'h0003, 16'h0005, 1);
        check("sub_borrow_out", m_out, 32'h0000FFFE);

        for (int i = 0; i < 20; i++)
            run_op(0, longint'($urandom_range(16'hFFFF)), longint'($urandom_range(16'hFFFF)), 1'($urandom_range(1)));

        // start pulsed mid-RUN with different operands is ignored
        sel = 0;
        op_a = 16'h3CC3; op_b = 16'h0FF0; op_sub = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        op_a = 16'hFFFF; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; op_a = 16'h0000;
        @(posedge clk); #1;
        check("ign_done_early", done0, 0);
        @(posedge clk); #1;
        check("ign_done", done0, 1);
        check("ign_out", out0, 16'h4CB3);
        @(posedge clk); #1;
        check("ign_idle", {busy0, done0}, 2'b00);

        // start held through done: back-to-back operations
        op_a = 16'h1111; op_b = 16'h2222; start_v[0] = 1'b1;
        @(posedge clk); #1;
        op_a = 16'h4000; op_b = 16'h4000;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        check("b2b_done1", done0, 1);
        check("b2b_out1", out0, 16'h3333);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check("b2b_restart", {busy0, done0}, 2'b10);
        check("b2b_hold", out0, 16'h3333);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        model(16, 16'h4000, 16'h4000, 0, r, c, v, z);
        check("b2b_done2", done0, 1);
        check("b2b_out2", out0, r);
        check("b2b_flags2", {c0, v0, z0}, {c, v, z});
        @(posedge clk); #1;
        check("b2b_done_fall", done0, 0);

        // reset mid-operation aborts without done
        op_a = 16'h0001; op_b = 16'h0001; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_out", out0, 16'h0000);
        check("abort_flags", {done0, c0, v0, z0}, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {busy0, done0}, 2'b00);
        end
        reset_prev();

        // single-pass and 8-bit configurations
        run_op(1, 16'hAAAA, 16'h5555, 0);
        check("single_pass_out", m_out, 32'h0000FFFF);
        for (int i = 0; i < 8; i++)
            run_op(1, longint'($urandom_range(16'hFFFF)), longint'($urandom_range(16'hFFFF)), 1'($urandom_range(1)));
        run_op(2, 8'h7F, 8'h01, 0);
        check("w8_ovf", {m_out, m_v}, {32'h00000080, 1'b1});
        for (int i = 0; i < 8; i++)
            run_op(2, longint'($urandom_range(8'hFF)), longint'($urandom_range(8'hFF)), 1'($urandom_range(1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
